// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with single-cycle ops and iterative signed mult/div into HI/LO
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         ALUOp,
    input  logic [1:0]         ShiftLeft,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_dvsr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_qneg;
    logic                 r_rneg;
    logic                 r_is_div;

    logic                 w_is_shift;
    logic                 w_is_iter;
    logic [WIDTH-1:0]     w_alu;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_is_shift = (ShiftLeft == 2'b01) || (ShiftLeft == 2'b10);
    assign w_is_iter  = !w_is_shift && ((ALUOp == OP_MULT) || (ALUOp == OP_DIV));
    assign w_a_mag    = a[WIDTH-1] ? -a : a;
    assign w_b_mag    = b[WIDTH-1] ? -b : b;

    always_comb begin
        w_alu = '0;
        case (ShiftLeft)
            2'b01:   w_alu = b << shamt;
            2'b10:   w_alu = b >> shamt;
            default: begin
                case (ALUOp)
                    OP_ADD:  w_alu = a + b;
                    OP_SUB:  w_alu = a - b;
                    OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    OP_OR:   w_alu = a | b;
                    OP_AND:  w_alu = a & b;
                    OP_NOT:  w_alu = ~a;
                    default: w_alu = '0;
                endcase
            end
        endcase
    end

    // Multiply: accumulator holds {partial product, remaining multiplier bits}
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                       + ({(WIDTH+1){r_acc[0]}} & {1'b0, r_dvsr});
    // Divide: accumulator holds {partial remainder, dividend/quotient bits}
    assign w_div_shift = {r_acc[2*WIDTH-2:0], 1'b0};
    assign w_div_trial = {1'b0, w_div_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_dvsr};

    assign w_prod   = r_qneg ? -r_acc : r_acc;
    assign w_quo    = r_qneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_is_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_is_iter) begin
                            result <= w_alu;
                            zero   <= (w_alu == '0);
                            done   <= 1'b1;
                        end else if ((ALUOp == OP_DIV) && (b == '0)) begin
                            result      <= '0;
                            zero        <= 1'b1;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                            r_dvsr   <= w_b_mag;
                            r_qneg   <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_rneg   <= a[WIDTH-1];
                            r_is_div <= (ALUOp == OP_DIV);
                            r_cnt    <= '0;
                            busy     <= 1'b1;
                            r_state  <= (ALUOp == OP_DIV) ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (!w_div_trial[WIDTH]) begin
                        r_acc <= {w_div_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};
                    end else begin
                        r_acc <= w_div_shift;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi      <= w_fix_hi;
                    lo      <= w_fix_lo;
                    result  <= w_fix_lo;
                    zero    <= (w_fix_lo == '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alu_op = '0;
    logic [1:0]  shift_left = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .ShiftLeft(shift_left),
        .a(a_i), .b(b_i), .shamt(shamt_i), .busy(busy), .done(done), .result(result),
        .zero(zero), .hi(hi), .lo(lo), .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          busy_n;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            sb_q.delete();
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.tag, "_result"}, result, mon_e.res);
                    check({mon_e.tag, "_zero"}, zero, mon_e.z);
                    check({mon_e.tag, "_hi"}, hi, mon_e.hi);
                    check({mon_e.tag, "_lo"}, lo, mon_e.lo);
                    check({mon_e.tag, "_dbz"}, dbz, mon_e.dbz);
                    check({mon_e.tag, "_busy_cycles"}, busy_cnt, mon_e.busy_n);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [1:0] sl, input logic [31:0] av,
                            input logic [31:0] bv, input logic [4:0] sh, input string tag);
        exp_t   e;
        longint sa, sbv, p, q, r;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        e.dbz = 1'b0;
        e.busy_n = 0;
        e.tag = tag;
        e.res = '0;
        if (sl == 2'b01) e.res = bv << sh;
        else if (sl == 2'b10) e.res = bv >> sh;
        else begin
            case (op)
                3'd0: e.res = av + bv;
                3'd1: e.res = av - bv;
                3'd2: begin
                    p = sa * sbv;
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                    e.res = m_lo;
                    e.busy_n = 33;
                end
                3'd3: begin
                    if (bv == 32'd0) begin
                        e.res = '0;
                        e.dbz = 1'b1;
                    end else begin
                        q = sa / sbv;
                        r = sa % sbv;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                        e.res = m_lo;
                        e.busy_n = 33;
                    end
                end
                3'd4: e.res = (sa < sbv) ? 32'd1 : 32'd0;
                3'd5: e.res = av | bv;
                3'd6: e.res = av & bv;
                default: e.res = ~av;
            endcase
        end
        e.z = (e.res == 32'd0);
        e.hi = m_hi;
        e.lo = m_lo;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] sl, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        alu_op = op;
        shift_left = sl;
        a_i = av;
        b_i = bv;
        shamt_i = sh;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] sl, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh, input string tag);
        @(negedge clk);
        #1;
        drive(op, sl, av, bv, sh);
        push_exp(op, sl, av, bv, sh, tag);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 80) begin
            @(negedge clk);
            #1;
            i++;
        end
        check({tag, "_drained"}, sb_q.size(), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [1:0] sl, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] sh, input string tag);
        issue(op, sl, av, bv, sh, tag);
        wait_idle(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int i;
        logic [2:0]  r_op;
        logic [1:0]  r_sl;
        logic [31:0] r_a, r_b;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", dbz, 0);
        #1 rst_n = 1'b1;

        run_op(3'b000, 2'b00, 32'd5, 32'd7, 5'd0, "add_5_7");
        run_op(3'b001, 2'b00, 32'd3, 32'd3, 5'd0, "sub_zero");
        run_op(3'b011, 2'b10, 32'h1234, 32'h8000_0000, 5'd31, "srl_over_div");

        issue(3'b010, 2'b00, -32'sd3, 32'd4, 5'd0, "mult_m3_4");
        repeat (8) @(negedge clk);
        #1;
        drive(3'b000, 2'b00, 32'd1, 32'd1, 5'd0);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("mult_busy_during", busy, 1);
        wait_idle("mult_m3_4");

        run_op(3'b011, 2'b00, -32'sd7, 32'd2, 5'd0, "div_m7_2");
        run_op(3'b011, 2'b00, 32'd9, 32'd0, 5'd0, "div_by_zero");

        issue(3'b010, 2'b00, 32'd6, 32'd7, 5'd0, "mult_reset");
        repeat (12) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_result", result, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_op(3'b000, 2'b00, 32'd10, 32'd20, 5'd0, "add_after_rst");

        issue(3'b010, 2'b00, 32'd2, 32'd3, 5'd0, "b2b_mult");
        i = 0;
        while (!done && i < 60) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("b2b_done_seen", done, 1);
        drive(3'b000, 2'b00, 32'd1, 32'd1, 5'd0);
        push_exp(3'b000, 2'b00, 32'd1, 32'd1, 5'd0, "b2b_add");
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle("b2b");

        run_op(3'b100, 2'b00, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt_neg_pos");
        run_op(3'b100, 2'b00, 32'd1, 32'hFFFF_FFFF, 5'd0, "slt_pos_neg");
        run_op(3'b111, 2'b00, 32'h0F0F_0000, 32'hFFFF_FFFF, 5'd0, "not");
        run_op(3'b101, 2'b00, 32'hF000_0001, 32'h0000_0F10, 5'd0, "or");
        run_op(3'b110, 2'b00, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, "and");
        run_op(3'b010, 2'b01, 32'd0, 32'h0000_0003, 5'd30, "sll_over_mult");
        run_op(3'b000, 2'b11, 32'hFFFF_FFFF, 32'd1, 5'd4, "reserved_shift_add");
        run_op(3'b011, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "div_min_m1");
        run_op(3'b011, 2'b00, 32'd7, -32'sd2, 5'd0, "div_7_m2");
        run_op(3'b010, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd0, "mult_min_min");

        for (int k = 0; k < 24; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_sl = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(r_op, r_sl, r_a, r_b, 5'($urandom_range(0, 31)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
